// File: rtl/mixer_key_pkg.sv
// Shared key codes, entry-FSM state type and accumulator width for the
// mixer keypad controller.
package mixer_key_pkg;

   localparam int KEY_W = 5;
   localparam int ACC_W = 10;

   localparam logic [KEY_W-1:0] KEY_DIG_MAX = 5'd9;
   localparam logic [KEY_W-1:0] KEY_SEL0    = 5'd10;
   localparam logic [KEY_W-1:0] KEY_SEL_MAX = 5'd13;
   localparam logic [KEY_W-1:0] KEY_ENTER   = 5'd16;
   localparam logic [KEY_W-1:0] KEY_CLEAR   = 5'd17;
   localparam logic [KEY_W-1:0] KEY_UP      = 5'd18;
   localparam logic [KEY_W-1:0] KEY_DOWN    = 5'd19;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHAN   = 2'd1,
      DIGITS = 2'd2
   } state_t;

endpackage

// File: rtl/mixer_key_debounce.sv
// Release-time debouncer: a press is accepted only after the strobe has been
// low for HOLD_CYCLES consecutive cycles; accept is a registered one-cycle pulse.
module key_debounce
   import mixer_key_pkg::*;
#(
   parameter int HOLD_CYCLES = 20000
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             key_strobe,
   input  logic [KEY_W-1:0] key_code,
   output logic             accept,
   output logic [KEY_W-1:0] code_q
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LST = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_armed;
   logic             r_accept;
   logic [KEY_W-1:0] r_code;

   // armed is set on the cycle the count reaches HOLD_CYCLES, so a press
   // directly following exactly HOLD_CYCLES low cycles is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_armed  <= 1'b0;
         r_accept <= 1'b0;
         r_code   <= '0;
      end else begin
         r_accept <= key_strobe & r_armed;
         if (key_strobe) begin
            r_cnt <= '0;
            if (r_armed) begin
               r_armed <= 1'b0;
               r_code  <= key_code;
            end
         end else begin
            if (r_cnt < HOLD_MAX) r_cnt <= r_cnt + 1'b1;
            if (r_cnt >= HOLD_LST) r_armed <= 1'b1;
         end
      end
   end

   assign accept = r_accept;
   assign code_q = r_code;

endmodule

// File: rtl/mixer_key_ctrl.sv
// Keypad entry controller: debounced key codes drive a select/digits/enter FSM
// that owns the per-channel volume registers and emits one-cycle write pulses.
module mixer_key_ctrl
   import mixer_key_pkg::*;
#(
   parameter int NCHAN       = 4,
   parameter int VOL_W       = 8,
   parameter int VOL_MAX     = 255,
   parameter int VOL_DEFAULT = 128,
   parameter int HOLD_CYCLES = 20000
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEY_W-1:0]       key_code,
   input  logic                   key_strobe,
   output logic                   wr_en,
   output logic [1:0]             wr_chan,
   output logic [VOL_W-1:0]       wr_data,
   output logic [NCHAN*VOL_W-1:0] vol,
   output logic [1:0]             sel_chan,
   output logic                   chan_valid,
   output logic                   key_err
);

   localparam logic [VOL_W-1:0] VMAX = VOL_W'(VOL_MAX);

   logic             w_accept;
   logic [KEY_W-1:0] w_code;

   key_debounce #(.HOLD_CYCLES(HOLD_CYCLES)) u_deb (
      .clk        (clk),
      .rst        (rst),
      .key_strobe (key_strobe),
      .key_code   (key_code),
      .accept     (w_accept),
      .code_q     (w_code)
   );

   state_t                      r_state, w_nxt_state;
   logic [ACC_W-1:0]            r_acc, w_nxt_acc;
   logic [1:0]                  r_ndig, w_nxt_ndig;
   logic [1:0]                  r_sel, w_nxt_sel;
   logic [NCHAN-1:0][VOL_W-1:0] r_vol;
   logic                        r_wr_en, r_key_err;
   logic [1:0]                  r_wr_chan;
   logic [VOL_W-1:0]            r_wr_data;

   logic                        w_wr, w_err;
   logic [VOL_W-1:0]            w_wr_data, w_cur;
   logic [1:0]                  w_ch;

   // Select codes 10..13 map to channels 0..3 via their two low bits.
   assign w_ch = w_code[1:0] + 2'd2;

   always_comb begin
      w_cur = '0;
      for (int i = 0; i < NCHAN; i++)
         if (r_sel == 2'(i)) w_cur = r_vol[i];
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_acc   = r_acc;
      w_nxt_ndig  = r_ndig;
      w_nxt_sel   = r_sel;
      w_wr        = 1'b0;
      w_wr_data   = '0;
      w_err       = 1'b0;
      if (w_accept) begin
         if (w_code >= KEY_SEL0 && w_code <= KEY_SEL_MAX) begin
            if (int'(w_ch) < NCHAN) begin
               w_nxt_sel   = w_ch;
               w_nxt_acc   = '0;
               w_nxt_ndig  = 2'd0;
               w_nxt_state = CHAN;
            end else begin
               w_err = 1'b1;
            end
         end else if (w_code <= KEY_DIG_MAX) begin
            if (r_state == IDLE || r_ndig == 2'd3) begin
               w_err = 1'b1;
            end else begin
               w_nxt_acc   = r_acc * ACC_W'(10) + ACC_W'(w_code[3:0]);
               w_nxt_ndig  = r_ndig + 2'd1;
               w_nxt_state = DIGITS;
            end
         end else begin
            case (w_code)
               KEY_ENTER: begin
                  if (r_state == DIGITS) begin
                     w_wr        = 1'b1;
                     w_wr_data   = (int'(r_acc) > VOL_MAX) ? VMAX : VOL_W'(r_acc);
                     w_nxt_acc   = '0;
                     w_nxt_ndig  = 2'd0;
                     w_nxt_state = CHAN;
                  end else begin
                     w_err = 1'b1;
                  end
               end
               KEY_CLEAR: begin
                  if (r_state == DIGITS) begin
                     w_nxt_acc   = '0;
                     w_nxt_ndig  = 2'd0;
                     w_nxt_state = CHAN;
                  end else if (r_state == CHAN) begin
                     w_nxt_sel   = 2'd0;
                     w_nxt_state = IDLE;
                  end
               end
               KEY_UP, KEY_DOWN: begin
                  if (r_state == IDLE) begin
                     w_err = 1'b1;
                  end else begin
                     // Saturated steps still issue a write.
                     w_wr = 1'b1;
                     if (w_code == KEY_UP)
                        w_wr_data = (w_cur >= VMAX) ? VMAX : w_cur + 1'b1;
                     else
                        w_wr_data = (w_cur == '0) ? '0 : w_cur - 1'b1;
                     w_nxt_acc   = '0;
                     w_nxt_ndig  = 2'd0;
                     w_nxt_state = CHAN;
                  end
               end
               default: w_err = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_ndig    <= 2'd0;
         r_sel     <= 2'd0;
         r_wr_en   <= 1'b0;
         r_wr_chan <= 2'd0;
         r_wr_data <= '0;
         r_key_err <= 1'b0;
         for (int i = 0; i < NCHAN; i++) r_vol[i] <= VOL_W'(VOL_DEFAULT);
      end else begin
         r_state   <= w_nxt_state;
         r_acc     <= w_nxt_acc;
         r_ndig    <= w_nxt_ndig;
         r_sel     <= w_nxt_sel;
         r_wr_en   <= w_wr;
         r_key_err <= w_err;
         if (w_wr) begin
            r_wr_chan <= r_sel;
            r_wr_data <= w_wr_data;
         end
         for (int i = 0; i < NCHAN; i++)
            if (w_wr && r_sel == 2'(i)) r_vol[i] <= w_wr_data;
      end
   end

   for (genvar g = 0; g < NCHAN; g++) begin : g_vol
      assign vol[g*VOL_W +: VOL_W] = r_vol[g];
   end

   assign wr_en      = r_wr_en;
   assign wr_chan    = r_wr_chan;
   assign wr_data    = r_wr_data;
   assign key_err    = r_key_err;
   assign sel_chan   = r_sel;
   assign chan_valid = (r_state != IDLE);

endmodule

// File: tb/tb_mixer_key_ctrl.sv
// Bench: two controllers (4 and 2 channels) share one keypad; a key-level
// model predicts every output each cycle, plus directed literal checks.
module tb_mixer_key_ctrl;

   localparam int HOLD = 4;
   localparam int VMAX = 255;
   localparam int VDEF = 128;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] key_code = 5'd0;
   logic       key_strobe = 1'b0;

   logic        wr_en4, key_err4, cv4, wr_en2, key_err2, cv2;
   logic [1:0]  wr_chan4, sel4, wr_chan2, sel2;
   logic [7:0]  wr_data4, wr_data2;
   logic [31:0] vol4;
   logic [15:0] vol2;

   always #5 clk = ~clk;

   mixer_key_ctrl #(.NCHAN(4), .VOL_W(8), .VOL_MAX(VMAX), .VOL_DEFAULT(VDEF), .HOLD_CYCLES(HOLD)) dut4 (
      .clk(clk), .rst(rst), .key_code(key_code), .key_strobe(key_strobe),
      .wr_en(wr_en4), .wr_chan(wr_chan4), .wr_data(wr_data4), .vol(vol4),
      .sel_chan(sel4), .chan_valid(cv4), .key_err(key_err4));

   mixer_key_ctrl #(.NCHAN(2), .VOL_W(8), .VOL_MAX(VMAX), .VOL_DEFAULT(VDEF), .HOLD_CYCLES(HOLD)) dut2 (
      .clk(clk), .rst(rst), .key_code(key_code), .key_strobe(key_strobe),
      .wr_en(wr_en2), .wr_chan(wr_chan2), .wr_data(wr_data2), .vol(vol2),
      .sel_chan(sel2), .chan_valid(cv2), .key_err(key_err2));

   int n_tests = 0;
   int n_fail  = 0;

   // Key-level model: entry mode 0 none, 1 channel only, 2 typing digits.
   int m_st[2], m_acc[2], m_nd[2], m_sel[2];
   int m_vol[2][4];
   bit e_wr[2], e_err[2];
   int e_chan[2], e_data[2];
   bit pend;
   int pend_code;
   int lowcnt;
   int wr_cnt[2], err_cnt[2], last_chan[2], last_data[2];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int nch(input int m);
      return (m == 0) ? 4 : 2;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_st[m] = 0; m_acc[m] = 0; m_nd[m] = 0; m_sel[m] = 0;
         e_wr[m] = 0; e_err[m] = 0; e_chan[m] = 0; e_data[m] = 0;
         for (int c = 0; c < 4; c++) m_vol[m][c] = VDEF;
      end
      pend = 0;
      lowcnt = 0;
   endtask

   task automatic do_write(input int m, input int v);
      e_wr[m] = 1; e_chan[m] = m_sel[m]; e_data[m] = v;
      m_vol[m][m_sel[m]] = v;
   endtask

   task automatic apply_key(input int m, input int c);
      int v;
      if (c >= 10 && c <= 13) begin
         if (c - 10 < nch(m)) begin
            m_sel[m] = c - 10; m_acc[m] = 0; m_nd[m] = 0; m_st[m] = 1;
         end else e_err[m] = 1;
      end else if (c <= 9) begin
         if (m_st[m] == 0 || m_nd[m] == 3) e_err[m] = 1;
         else begin
            m_acc[m] = m_acc[m] * 10 + c; m_nd[m]++; m_st[m] = 2;
         end
      end else if (c == 16) begin
         if (m_st[m] == 2) begin
            do_write(m, (m_acc[m] > VMAX) ? VMAX : m_acc[m]);
            m_acc[m] = 0; m_nd[m] = 0; m_st[m] = 1;
         end else e_err[m] = 1;
      end else if (c == 17) begin
         if (m_st[m] == 2) begin
            m_acc[m] = 0; m_nd[m] = 0; m_st[m] = 1;
         end else if (m_st[m] == 1) begin
            m_st[m] = 0; m_sel[m] = 0;
         end
      end else if (c == 18 || c == 19) begin
         if (m_st[m] == 0) e_err[m] = 1;
         else begin
            v = m_vol[m][m_sel[m]];
            if (c == 18) v = (v >= VMAX) ? VMAX : v + 1;
            else         v = (v == 0) ? 0 : v - 1;
            do_write(m, v);
            m_acc[m] = 0; m_nd[m] = 0; m_st[m] = 1;
         end
      end else e_err[m] = 1;
   endtask

   task automatic compare_all();
      int a_wr, a_err, a_ch, a_dat, a_cv, a_sel, a_v;
      for (int m = 0; m < 2; m++) begin
         a_wr  = (m == 0) ? int'(wr_en4)   : int'(wr_en2);
         a_err = (m == 0) ? int'(key_err4) : int'(key_err2);
         a_ch  = (m == 0) ? int'(wr_chan4) : int'(wr_chan2);
         a_dat = (m == 0) ? int'(wr_data4) : int'(wr_data2);
         a_cv  = (m == 0) ? int'(cv4)      : int'(cv2);
         a_sel = (m == 0) ? int'(sel4)     : int'(sel2);
         chk($sformatf("wr_en[dut%0d]", nch(m)), a_wr, int'(e_wr[m]));
         chk($sformatf("key_err[dut%0d]", nch(m)), a_err, int'(e_err[m]));
         chk($sformatf("chan_valid[dut%0d]", nch(m)), a_cv, (m_st[m] != 0) ? 1 : 0);
         chk($sformatf("sel_chan[dut%0d]", nch(m)), a_sel, m_sel[m]);
         if (e_wr[m]) begin
            chk($sformatf("wr_chan[dut%0d]", nch(m)), a_ch, e_chan[m]);
            chk($sformatf("wr_data[dut%0d]", nch(m)), a_dat, e_data[m]);
         end
         for (int c = 0; c < nch(m); c++) begin
            a_v = (m == 0) ? int'(vol4[c*8 +: 8]) : int'(vol2[c*8 +: 8]);
            chk($sformatf("vol%0d[dut%0d]", c, nch(m)), a_v, m_vol[m][c]);
         end
         if (a_wr != 0) begin
            wr_cnt[m]++; last_chan[m] = a_ch; last_data[m] = a_dat;
         end
         if (a_err != 0) err_cnt[m]++;
      end
   endtask

   // Negedge: outputs reflect the last rising edge, inputs are those the
   // next rising edge will sample, so compare first, then advance the model.
   initial begin
      model_reset();
      for (int m = 0; m < 2; m++) begin
         wr_cnt[m] = 0; err_cnt[m] = 0; last_chan[m] = 0; last_data[m] = 0;
      end
      forever begin
         @(negedge clk);
         compare_all();
         if (rst) model_reset();
         else begin
            for (int m = 0; m < 2; m++) begin
               e_wr[m] = 0; e_err[m] = 0;
               if (pend) apply_key(m, pend_code);
            end
            pend = key_strobe && (lowcnt >= HOLD);
            pend_code = int'(key_code);
            if (key_strobe) lowcnt = 0;
            else if (lowcnt < HOLD) lowcnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int c);
      key_code = 5'(c);
      key_strobe = 1'b1;
      repeat (3) tick();
      key_strobe = 1'b0;
      repeat (5) tick();
   endtask

   int w0, e0, e1;
   task automatic snap();
      w0 = wr_cnt[0]; e0 = err_cnt[0]; e1 = err_cnt[1];
   endtask

   initial begin
      repeat (3) tick();
      chk("reset wr_en", int'(wr_en4), 0);
      chk("reset wr_chan", int'(wr_chan4), 0);
      chk("reset wr_data", int'(wr_data4), 0);
      chk("reset vol", (vol4 == 32'h80808080) ? 1 : 0, 1);
      chk("reset chan_valid", int'(cv4), 0);
      chk("reset key_err", int'(key_err4), 0);
      rst = 1'b0;
      repeat (4) tick();

      snap();
      press(10); press(1); press(2); press(0); press(16);
      chk("t1 write count", wr_cnt[0] - w0, 1);
      chk("t1 err count", err_cnt[0] - e0, 0);
      chk("t1 wr_chan", last_chan[0], 0);
      chk("t1 wr_data", last_data[0], 120);
      chk("t1 vol0", int'(vol4[7:0]), 120);

      snap();
      press(11); press(9); press(9); press(9); press(5); press(16);
      chk("t2 err count", err_cnt[0] - e0, 1);
      chk("t2 write count", wr_cnt[0] - w0, 1);
      chk("t2 wr_chan", last_chan[0], 1);
      chk("t2 wr_data clamp", last_data[0], 255);

      press(12);
      snap();
      key_code = 5'd18;
      key_strobe = 1'b1; tick();
      key_strobe = 1'b0; repeat (2) tick();
      key_strobe = 1'b1; tick();
      key_strobe = 1'b0; repeat (5) tick();
      chk("t3 bounce write count", wr_cnt[0] - w0, 1);
      chk("t3 wr_chan", last_chan[0], 2);
      chk("t3 wr_data", last_data[0], 129);

      press(10); press(2); press(5); press(5); press(16);
      press(18);
      chk("t4 up saturate", last_data[0], 255);
      press(0); press(16);
      snap();
      press(19);
      chk("t4 down saturate write", wr_cnt[0] - w0, 1);
      chk("t4 down saturate", last_data[0], 0);
      snap();
      press(17); press(17);
      chk("t4 clear chan_valid", int'(cv4), 0);
      chk("t4 clear no err", err_cnt[0] - e0, 0);

      snap();
      press(5);
      chk("t5 digit in idle err", err_cnt[0] - e0, 1);
      press(12);
      chk("t5 nchan2 sel err", err_cnt[1] - e1, 2);
      chk("t5 nchan2 stays idle", int'(cv2), 0);
      chk("t5 nchan4 sel ch2", int'(sel4), 2);
      press(15);
      chk("t5 key15 err", err_cnt[0] - e0, 2);
      press(17);

      press(10); press(4); press(5);
      snap();
      key_code = 5'd16;
      key_strobe = 1'b1; tick();
      rst = 1'b1; tick();
      rst = 1'b0; repeat (3) tick();
      chk("t6 write cancelled", wr_cnt[0] - w0, 0);
      chk("t6 vol4 default", (vol4 == 32'h80808080) ? 1 : 0, 1);
      chk("t6 vol2 default", (vol2 == 16'h8080) ? 1 : 0, 1);
      chk("t6 idle", int'(cv4), 0);
      key_strobe = 1'b0; repeat (3) tick();
      key_strobe = 1'b1; tick();
      key_strobe = 1'b0; repeat (2) tick();
      chk("t6 held key ignored", err_cnt[0] - e0, 0);
      repeat (4) tick();
      press(16);
      chk("t6 key after release", err_cnt[0] - e0, 1);

      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end
         key_code = 5'($urandom_range(0, 19));
         key_strobe = 1'b1;
         repeat ($urandom_range(1, 4)) tick();
         key_strobe = 1'b0;
         repeat ($urandom_range(1, 7)) tick();
      end
      repeat (8) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
